// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs.sv
// One-bit full-subtractor cell: Diff = A - B - Borrow_in.
module fs (
    input  logic A,
    input  logic B,
    input  logic Borrow_in,
    output logic Diff,
    output logic Borrow_out
);

    assign Diff       = A ^ B ^ Borrow_in;
    assign Borrow_out = (~A & B) | (~(A ^ B) & Borrow_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a single fs cell.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign Diff       = r_diff;
    assign Borrow_out = r_bout;

    fs u_fs (
        .A          (r_a[0]),
        .B          (r_b[0]),
        .Borrow_in  (r_borrow),
        .Diff       (w_d),
        .Borrow_out (w_bo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-bit shifting, and result publish on the final bit only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a      <= A;
                r_b      <= B;
                r_borrow <= Borrow_in;
                r_cnt    <= '0;
            end
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_bo;
            r_res    <= {w_d, r_res[WIDTH-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            // Partial results stay in r_res; Diff only moves when the last bit lands.
            if (w_last) begin
                r_diff <= {w_d, r_res[WIDTH-1:1]};
                r_bout <= w_bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 directed vectors plus WIDTH=2 sweep.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .A          (a8),
        .B          (b8),
        .Borrow_in  (bin8),
        .busy       (busy8),
        .done       (done8),
        .Diff       (diff8),
        .Borrow_out (bout8)
    );

    serial_sub #(.WIDTH(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .A          (a2),
        .B          (b2),
        .Borrow_in  (bin2),
        .busy       (busy2),
        .done       (done2),
        .Diff       (diff2),
        .Borrow_out (bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // mode 0: plain op; 1: change operands mid-op; 2: extra start pulse at SHIFT cycle 3.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int mode, output int lat, output int nbusy,
                       output int ndone, output int nearly);
        logic [7:0] prev;
        prev   = diff8;
        lat    = 0;
        nbusy  = 0;
        ndone  = 0;
        nearly = 0;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        // e counts edges with the accepting edge as 1
        for (int e = 1; e <= 14; e++) begin
            if (busy8) nbusy++;
            if (done8) begin
                ndone++;
                if (lat == 0) lat = e;
            end
            if (e < 9 && diff8 !== prev) nearly++;
            if (mode == 1 && e == 3) begin
                a8 = ~a; b8 = ~b; bin8 = ~bin;
            end
            if (mode == 2 && e == 3) begin
                a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
            end
            if (mode == 2 && e == 4) start8 = 1'b0;
            if (e < 14) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   lat, nbusy, ndone, nearly;
        int   last_done;
        bit   found;
        logic [1:0] ea, eb, ed;
        logic       ebi, ebo;

        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, diff: 8'h02, bout: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h7F, bin: 1'b1, diff: 8'h00, bout: 1'b0};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, diff: 8'h4B, bout: 1'b0};
        vecs[5] = '{a: 8'h10, b: 8'h20, bin: 1'b1, diff: 8'hEF, bout: 1'b1};
        vecs[6] = '{a: 8'hFF, b: 8'h00, bin: 1'b0, diff: 8'hFF, bout: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_bout8", 32'(bout8), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_diff2", 32'(diff2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, 0, lat, nbusy, ndone, nearly);
            chk($sformatf("vec%0d_diff", i), 32'(diff8), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_bout", i), 32'(bout8), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd9);
            chk($sformatf("vec%0d_busy", i), 32'(nbusy), 32'd8);
            chk($sformatf("vec%0d_ndone", i), 32'(ndone), 32'd1);
            chk($sformatf("vec%0d_early", i), 32'(nearly), 32'd0);
        end

        // Operands change after acceptance
        op8(8'h80, 8'h7F, 1'b1, 1, lat, nbusy, ndone, nearly);
        chk("midchg_diff", 32'(diff8), 32'h00);
        chk("midchg_bout", 32'(bout8), 32'd0);
        chk("midchg_ndone", 32'(ndone), 32'd1);

        // Second start during SHIFT is ignored
        op8(8'hC3, 8'h41, 1'b0, 2, lat, nbusy, ndone, nearly);
        chk("restart_diff", 32'(diff8), 32'h82);
        chk("restart_bout", 32'(bout8), 32'd0);
        chk("restart_ndone", 32'(ndone), 32'd1);
        chk("restart_lat", 32'(lat), 32'd9);

        // Reset at SHIFT cycle 4 aborts; rst beats start
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_bout", 32'(bout8), 32'd0);
        @(posedge clk); #1;
        chk("rst_prio_busy", 32'(busy8), 32'd0);
        rst = 1'b0; start8 = 1'b0;
        ndone = 0; nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
            if (busy8) nbusy++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_no_busy", 32'(nbusy), 32'd0);
        op8(8'h40, 8'h01, 1'b0, 0, lat, nbusy, ndone, nearly);
        chk("post_rst_diff", 32'(diff8), 32'h3F);
        chk("post_rst_bout", 32'(bout8), 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd9);

        // WIDTH=2 sweep with start held high
        last_done = 0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            @(negedge clk);
            a2 = v[4:3]; b2 = v[2:1]; bin2 = v[0]; start2 = 1'b1;
            ea = v[4:3]; eb = v[2:1]; ebi = v[0];
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(posedge clk); #1;
                if (done2) found = 1'b1;
            end
            chk($sformatf("w2_%0d_seen", i), 32'(found), 32'd1);
            ed  = ea - eb - 2'(ebi);
            ebo = ({1'b0, ea} < ({1'b0, eb} + 3'(ebi)));
            chk($sformatf("w2_%0d_diff", i), 32'(diff2), 32'(ed));
            chk($sformatf("w2_%0d_bout", i), 32'(bout2), 32'(ebo));
            if (i > 0) chk($sformatf("w2_%0d_period", i), 32'(cyc - last_done), 32'd4);
            last_done = cyc;
        end
        start2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
